// File: rtl/requant_writeback.sv
// Requantize int32 accumulator rows from the C buffer to packed int8 words (TFLite semantics).
// One row per cycle; C_index -> O_wr_en latency is 5 cycles.
module requant_writeback #(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [IDX_W-1:0]        num_entries,
  input  logic [32*NUM_LANES-1:0] bias,
  input  logic [31:0]             multiplier,
  input  logic [4:0]              shift,
  input  logic [31:0]             out_offset,
  input  logic [7:0]              act_min,
  input  logic [7:0]              act_max,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        C_index,
  input  logic [32*NUM_LANES-1:0] C_data_out,
  output logic                    O_wr_en,
  output logic [IDX_W-1:0]        O_index,
  output logic [8*NUM_LANES-1:0]  O_data_in
);

  localparam logic [31:0] I32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] I32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  r_state;
  logic                    r_busy, r_done, r_wr;
  logic [IDX_W-1:0]        r_cidx, r_oidx, r_n;
  logic [8*NUM_LANES-1:0]  r_odata;

  logic [32*NUM_LANES-1:0] r_bias;
  logic [31:0]             r_mult, r_off;
  logic [4:0]              r_shift;
  logic [7:0]              r_amin, r_amax;

  logic                    r_v1, r_v2, r_v3, r_v4;
  logic [IDX_W-1:0]        r_idx1, r_idx2, r_idx3, r_idx4;
  logic [31:0]             r_s1 [NUM_LANES];
  logic [63:0]             r_p  [NUM_LANES];
  logic                    r_mm [NUM_LANES];
  logic [31:0]             r_x  [NUM_LANES];

  logic [31:0]             w_s1 [NUM_LANES];
  logic [63:0]             w_p  [NUM_LANES];
  logic                    w_mm [NUM_LANES];
  logic [31:0]             w_x  [NUM_LANES];
  logic [8*NUM_LANES-1:0]  w_odata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int HI = NUM_LANES - 1 - g;

    logic [31:0]        w_acc, w_b;
    logic [32:0]        w_sum;
    logic [63:0]        w_q;
    logic signed [31:0] w_sh;
    logic [31:0]        w_mask, w_rem, w_thr, w_r;
    logic [32:0]        w_v;
    logic [31:0]        w_vs;
    logic signed [31:0] w_vsig, w_min, w_max;
    logic               w_below, w_above;

    assign w_acc    = C_data_out[32*HI +: 32];
    assign w_b      = r_bias[32*HI +: 32];
    assign w_sum    = {w_acc[31], w_acc} + {w_b[31], w_b};
    assign w_s1[g]  = (w_sum[32] != w_sum[31]) ? (w_sum[32] ? I32_MIN : I32_MAX) : w_sum[31:0];

    assign w_p[g]   = {{32{r_s1[g][31]}}, r_s1[g]} * {{32{r_mult[31]}}, r_mult};
    assign w_mm[g]  = (r_s1[g] == I32_MIN) && (r_mult == I32_MIN);

    // Truncating divide by 2^31: floor quotient, plus one when negative with a nonzero remainder
    assign w_q      = r_p[g] + (r_p[g][63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000);
    assign w_x[g]   = r_mm[g] ? I32_MAX : (w_q[62:31] + {31'b0, w_q[63] & (|w_q[30:0])});

    assign w_sh     = $signed(r_x[g]) >>> r_shift;
    assign w_mask   = (32'd1 << r_shift) - 32'd1;
    assign w_rem    = r_x[g] & w_mask;
    assign w_thr    = {1'b0, w_mask[31:1]} + {31'b0, r_x[g][31]};
    assign w_r      = w_sh + {31'b0, (w_rem > w_thr)};
    assign w_v      = {w_r[31], w_r} + {r_off[31], r_off};
    assign w_vs     = (w_v[32] != w_v[31]) ? (w_v[32] ? I32_MIN : I32_MAX) : w_v[31:0];

    // Min clamp first, then max, so a reversed range resolves to act_max
    assign w_vsig   = w_vs;
    assign w_min    = {{24{r_amin[7]}}, r_amin};
    assign w_max    = {{24{r_amax[7]}}, r_amax};
    assign w_below  = w_vsig < w_min;
    assign w_above  = w_below ? (w_min > w_max) : (w_vsig > w_max);
    assign w_odata[8*HI +: 8] = w_above ? r_amax : (w_below ? r_amin : w_vs[7:0]);
  end

  always_ff @(posedge clk) begin
    r_s1   <= w_s1;
    r_p    <= w_p;
    r_mm   <= w_mm;
    r_x    <= w_x;
    r_idx1 <= r_cidx;
    r_idx2 <= r_idx1;
    r_idx3 <= r_idx2;
    r_idx4 <= r_idx3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr    <= 1'b0;
      r_cidx  <= '0;
      r_oidx  <= '0;
      r_odata <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_v4    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_v1   <= (r_state == S_RUN);
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_v4   <= r_v3;
      r_wr   <= r_v4;
      if (r_v4) begin
        r_oidx  <= r_idx4;
        r_odata <= w_odata;
      end
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (in_valid && !r_busy) begin
            r_n     <= num_entries;
            r_bias  <= bias;
            r_mult  <= multiplier;
            r_shift <= shift;
            r_off   <= out_offset;
            r_amin  <= act_min;
            r_amax  <= act_max;
            r_cidx  <= '0;
            r_busy  <= 1'b1;
            // Empty job: busy and done share the single following cycle
            if (num_entries == '0) r_done  <= 1'b1;
            else                   r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cidx == r_n - IDX_W'(1)) r_state <= S_DRAIN;
          else                           r_cidx  <= r_cidx + IDX_W'(1);
        end
        S_DRAIN: begin
          if (!r_v1 && !r_v2 && !r_v3 && !r_v4) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign C_index   = r_cidx;
  assign O_wr_en   = r_wr;
  assign O_index   = r_oidx;
  assign O_data_in = r_odata;

endmodule

// File: tb/tb_requant_writeback.sv
// Scoreboard bench for requant_writeback: stimulus pushes expected writes, a monitor pops and compares.
module tb_requant_writeback;

  logic         clk = 1'b0;
  logic         reset, in_valid;
  logic [11:0]  num_entries;
  logic [127:0] bias;
  logic [31:0]  multiplier;
  logic [4:0]   shift;
  logic [31:0]  out_offset;
  logic [7:0]   act_min, act_max;
  logic         busy, done, O_wr_en;
  logic [11:0]  C_index, O_index;
  logic [127:0] C_data_out;
  logic [31:0]  O_data_in;

  always #5 clk = ~clk;

  requant_writeback #(.NUM_LANES(4), .IDX_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num_entries(num_entries),
    .bias(bias), .multiplier(multiplier), .shift(shift), .out_offset(out_offset),
    .act_min(act_min), .act_max(act_max), .busy(busy), .done(done),
    .C_index(C_index), .C_data_out(C_data_out), .O_wr_en(O_wr_en),
    .O_index(O_index), .O_data_in(O_data_in)
  );

  logic [127:0] cmem [0:4095];
  always @(posedge clk) C_data_out <= cmem[C_index];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] dir_exp[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, rounding shift as round-half-away-from-zero
  function automatic logic [7:0] ref_lane(input int acc, input int b, input int m, input int sh,
                                          input int off, input int amin, input int amax);
    longint lmax, lmin, s, p, x, a, r, v;
    lmax = 64'sd2147483647;
    lmin = -64'sd2147483648;
    s = longint'(acc) + longint'(b);
    if (s > lmax) s = lmax;
    if (s < lmin) s = lmin;
    if (s == lmin && longint'(m) == lmin) x = lmax;
    else begin
      p = s * longint'(m);
      if (p >= 0) p = p + 64'sd1073741824;
      else        p = p + 1 - 64'sd1073741824;
      x = p / 64'sd2147483648;
    end
    if (sh == 0) r = x;
    else begin
      a = (x < 0) ? -x : x;
      a = (a + (64'sd1 <<< (sh - 1))) >>> sh;
      r = (x < 0) ? -a : a;
    end
    v = r + longint'(off);
    if (v > lmax) v = lmax;
    if (v < lmin) v = lmin;
    if (v < amin) v = amin;
    if (v > amax) v = amax;
    return v[7:0];
  endfunction

  function automatic logic [31:0] ref_row(input logic [127:0] row);
    logic [31:0] res;
    for (int l = 0; l < 4; l++)
      res[31-8*l -: 8] = ref_lane(row[127-32*l -: 32], bias[127-32*l -: 32], multiplier,
                                  int'(shift), out_offset, $signed(act_min), $signed(act_max));
    return res;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (O_wr_en === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got index %0d data %08h, required no write (cycle %0d)",
                   O_index, O_data_in, cyc);
        end else begin
          e = sb.pop_front();
          if (O_index !== e.idx[11:0] || O_data_in !== e.data || cyc != e.at) begin
            miscompares++;
            $display("FAIL write: got idx %0d data %08h cycle %0d, required idx %0d data %08h cycle %0d",
                     O_index, O_data_in, cyc, e.idx, e.data, e.at);
          end
        end
      end
    end
  end

  task automatic run_job(input int n, input bit glitch);
    int t0, busy_cnt, done_cnt, done_cyc;
    logic [31:0] saved_mult;
    exp_t e;
    @(negedge clk);
    num_entries = 12'(n);
    in_valid    = 1'b1;
    t0          = cyc;
    for (int i = 0; i < n; i++) begin
      e.idx  = i;
      e.data = (i < dir_exp.size()) ? dir_exp[i] : ref_row(cmem[i]);
      e.at   = t0 + 6 + i;
      sb.push_back(e);
    end
    dir_exp.delete();
    @(negedge clk);
    in_valid = 1'b0;
    if (n > 0) check("first_c_index", 64'(C_index), 64'd0);
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    saved_mult = multiplier;
    for (int k = 0; k < 200; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (glitch && cyc == t0 + 3) begin
        in_valid    = 1'b1;
        num_entries = 12'd3;
        multiplier  = ~saved_mult;
      end
      if (glitch && cyc == t0 + 4) begin
        in_valid    = 1'b0;
        num_entries = 12'(n);
        multiplier  = saved_mult;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    check("done_cycle", 64'(done_cyc - t0), (n == 0) ? 64'd1 : 64'(n + 6));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_cycles", 64'(busy_cnt), (n == 0) ? 64'd1 : 64'(n + 5));
    check("pending_writes", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_reset_job();
    int t0, dcnt, bcnt;
    exp_t e;
    for (int i = 0; i < 8; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    num_entries = 12'd8;
    in_valid    = 1'b1;
    t0          = cyc;
    for (int i = 0; i < 3; i++) begin
      e.idx  = i;
      e.data = ref_row(cmem[i]);
      e.at   = t0 + 6 + i;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t0 + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_wr_en", 64'(O_wr_en), 64'd0);
    check("abort_c_index", 64'(C_index), 64'd0);
    check("abort_o_index", 64'(O_index), 64'd0);
    check("abort_o_data", 64'(O_data_in), 64'd0);
    reset = 1'b0;
    dcnt = 0;
    bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0) dcnt++;
      if (busy !== 1'b0) bcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    check("abort_no_busy", 64'(bcnt), 64'd0);
    check("abort_pending", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_word();
    if ($urandom_range(3, 0) == 0) return $urandom;
    return 32'(int'($urandom_range(2000000, 0)) - 1000000);
  endfunction

  initial begin
    logic [127:0] row;
    logic [7:0]   a, b;
    int           n;
    for (int i = 0; i < 4096; i++) cmem[i] = '0;
    reset = 1'b1; in_valid = 1'b0; num_entries = '0; bias = '0; multiplier = '0;
    shift = '0; out_offset = '0; act_min = 8'h80; act_max = 8'h7F;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(O_wr_en), 64'd0);
    check("rst_c_index", 64'(C_index), 64'd0);
    check("rst_o_index", 64'(O_index), 64'd0);
    check("rst_o_data", 64'(O_data_in), 64'd0);
    reset = 1'b0;

    // Basic single row
    cmem[0] = {4{32'd100}};
    multiplier = 32'h4000_0000; out_offset = -32'sd128;
    dir_exp.push_back(32'hB2B2_B2B2);
    run_job(1, 1'b0);

    // Rounding shift
    cmem[0] = {32'sd5, -32'sd5, 32'sd4, -32'sd4};
    multiplier = 32'h7FFF_FFFF; shift = 5'd1; out_offset = '0;
    dir_exp.push_back(32'h03FD_02FE);
    run_job(1, 1'b0);

    // Saturation and clamping, under both multipliers
    cmem[0] = {32'h8000_0000, 32'd1000000, -32'sd1000000, 32'h7FFF_FFFF};
    bias = {96'd0, 32'd1}; shift = '0;
    multiplier = 32'h8000_0000;
    dir_exp.push_back(32'h7F80_7F80);
    run_job(1, 1'b0);
    multiplier = 32'h4000_0000;
    dir_exp.push_back(32'h807F_807F);
    run_job(1, 1'b0);

    // Streaming with an ignored second start pulse mid-job
    bias = '0; out_offset = 32'd3;
    for (int i = 0; i < 8; i++) cmem[i] = {4{32'(i * 40000 - 150000)}};
    run_job(8, 1'b1);

    run_job(0, 1'b0);

    // Randomized jobs; the last one has a reversed clamp range
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(16, 1);
      for (int i = 0; i < n; i++) begin
        for (int l = 0; l < 4; l++) row[127-32*l -: 32] = rand_word();
        cmem[i] = row;
      end
      for (int l = 0; l < 4; l++) bias[127-32*l -: 32] = rand_word();
      multiplier = ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : $urandom;
      shift      = ($urandom_range(3, 0) == 0) ? 5'($urandom_range(31, 0)) : 5'($urandom_range(12, 0));
      out_offset = 32'(int'($urandom_range(255, 0)) - 128);
      a = 8'($urandom); b = 8'($urandom);
      if (($signed(a) > $signed(b)) != (j == 5)) begin act_min = b; act_max = a; end
      else begin act_min = a; act_max = b; end
      run_job(n, 1'b0);
    end

    act_min = 8'h80; act_max = 8'h7F;
    run_reset_job();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required $finish before 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/requant_writeback.md
Name: requant_writeback

Overview:
- Downstream stage of the TPU matmul core. Runs after the core drops busy.
- Streams the 128-bit int32 accumulator rows out of the C buffer (4 lanes per row) and requantizes each lane to int8 using TFLite semantics: bias add, fixed-point multiply, rounding shift, output offset and clamp.
- Packs the 4 int8 results into one 32-bit word per row and writes it to the output buffer.
- Throughput: one row per cycle with a fixed pipeline latency.

Parameters:
- NUM_LANES, 4, int32 lanes per C row (ARRAY_SIZE of the core); only 4 is supported.
- IDX_W, 12, width of buffer indices.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  start pulse; configuration inputs are sampled on this cycle.
- num_entries  in  12  number of C rows to process.
- bias  in  128  four signed int32 per-lane biases; lane0 = [127:96].
- multiplier  in  32  signed Q31 quantized multiplier.
- shift  in  5  right-shift exponent, 0..31.
- out_offset  in  32  signed output zero point.
- act_min  in  8  signed lower clamp.
- act_max  in  8  signed upper clamp.
- busy  out  1  high while the job is active.
- done  out  1  one-cycle pulse at job completion.
- C_index  out  12  C buffer read address.
- C_data_out  in  128  C row; valid one cycle after C_index is presented; lane0 = [127:96].
- O_wr_en  out  1  output buffer write strobe.
- O_index  out  12  output write address.
- O_data_in  out  32  packed int8 results; lane0 = [31:24].

Behaviour:
- Single clock clk; reset is synchronous, active-high, named reset.
- Reset values: busy=0, done=0, O_wr_en=0, C_index=0, O_index=0, O_data_in=0. All pipeline valid bits and counters are cleared.
- Reset has priority over everything. Reset mid-job aborts it: no further writes and no done pulse.
- States:
  - IDLE:
    - in_valid latches all configuration inputs, sets busy=1 next cycle and goes to RUN.
    - in_valid while busy is ignored.
  - RUN:
    - C_index presents 0,1,…,num_entries-1 on consecutive cycles, starting the first cycle busy=1.
    - After the last index is presented, go to DRAIN.
  - DRAIN:
    - Wait until the pipeline is empty.
    - Then pulse done=1 for one cycle, set busy=0 and return to IDLE.
- num_entries=0: RUN is skipped; done pulses the cycle after in_valid, busy is high for exactly that cycle, and no writes occur.
- Pipeline timing, for a row whose index is presented at cycle c:
  - c+1: C_data_out valid. Register s1 = sat32(acc + bias_lane), using a 33-bit sum saturated to the int32 range.
  - c+2: 64-bit signed product p = s1 * multiplier.
  - c+3: SRDHM result.
    - If s1 = multiplier = INT32_MIN, the result is INT32_MAX.
    - Otherwise nudge = (p>=0) ? 2^30 : 1-2^30, and the result is (p+nudge)/2^31, truncated toward zero.
  - c+4: rounding divide by 2^shift.
    - mask = 2^shift-1, rem = x & mask, thr = (mask>>1) + (x<0).
    - r = (x >>> shift) + (rem > thr).
    - Then v = r + out_offset, saturated to int32, then clamped to [act_min, act_max].
  - c+5: O_wr_en=1, O_index=row, O_data_in = packed lanes 0..3.
- Fixed latency: C_index → O_wr_en is 5 cycles. Writes for consecutive rows land on consecutive cycles with no bubbles.
- done pulses the cycle after the last O_wr_en.
- act_min > act_max is a configuration error. Result: the value is clamped to act_max after act_min is applied; no check is made.
- The block never drives C buffer write signals. The core must have deasserted busy before in_valid.

Test Plan:
- Basic: num_entries=1, all lanes acc=100, bias=0, multiplier=0x40000000, shift=0, out_offset=-128, act=[-128,127] → one write, O_index=0, O_data_in=0xB2B2B2B2; C_index=0 at cycle t+1, O_wr_en at t+6, done at t+7.
- Rounding shift: lanes acc={5,-5,4,-4}, multiplier=0x7FFFFFFF, shift=1, offset=0 → bytes {3,-3,2,-2} = 0x03FD02FE.
- Saturation/clamp: lane0 acc=INT32_MIN with multiplier=INT32_MIN → 0x7F; lane1 acc=1000000, multiplier 0x40000000 → 0x7F; lane2 acc=-1000000 → 0x80; lane3 acc=0x7FFFFFFF with bias=1 (bias saturates) → 0x7F.
- Streaming: num_entries=8 with distinct rows → 8 writes on 8 consecutive cycles, O_index 0..7 in order, busy high for 13 cycles, a single done pulse.
- Edge control: num_entries=0 → no O_wr_en, done the cycle after in_valid. A second in_valid during busy is ignored. Reset asserted at write 3 of 8 → outputs at reset values next cycle, no done.
